if_pc_gen: RTL and testbench
============================

IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush_i, input, 1, exception redirect from pipeline controller.
REQ-004 SHALL have port new_pc_i, input, 32, exception target, valid with flush_i.
REQ-005 SHALL have port branch_flag_i, input, 1, taken-branch redirect from ID.
REQ-006 SHALL have port branch_target_i, input, 32, branch target, valid with branch_flag_i.
REQ-007 SHALL have port pc_instr_invalid_i, input, 1, kill instruction held in output slot.
REQ-008 SHALL have ports req_valid_o/out/1, req_addr_o/out/32, req_ready_i/in/1: instruction-memory request handshake.
REQ-009 SHALL have ports resp_valid_i/in/1, resp_instr_i/in/32: instruction-memory response, in-order, no backpressure.
REQ-010 SHALL have ports if_valid_o/out/1, if_pc_o/out/32, if_instr_o/out/32, if_excp_o/out/1, id_ready_i/in/1: fetch-to-ID handshake.
REQ-011 SHALL have parameter RESET_PC, default 32'h1C00_0000, first fetch address.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, DROP; IDLE on reset.
REQ-013 IDLE SHALL go to REQ one cycle after reset release; pc = RESET_PC.
REQ-014 REQ SHALL assert req_valid_o with req_addr_o = pc when output slot is empty or being consumed this cycle (if_valid_o && id_ready_i); req_valid_o && req_ready_i -> WAIT.
REQ-015 req_valid_o SHALL, once asserted, hold with stable req_addr_o until accepted unless a redirect occurs.
REQ-016 WAIT with resp_valid_i and no redirect SHALL load output slot {pc, resp_instr_i}, set if_valid_o, pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), go REQ.
REQ-017 Redirect priority SHALL be flush_i > branch_flag_i > sequential; redirect sets pc to new_pc_i or branch_target_i in the same edge.
REQ-018 Redirect in REQ (unaccepted) SHALL drop the pending request; next cycle request uses new pc.
REQ-019 Redirect in WAIT without same-cycle resp_valid_i SHALL go DROP; DROP discards the next response then goes REQ.
REQ-020 Redirect in WAIT with same-cycle resp_valid_i SHALL discard that response and go REQ.
REQ-021 flush_i or pc_instr_invalid_i SHALL clear if_valid_o next edge; branch_flag_i alone SHALL clear if_valid_o unless the slot is being consumed that cycle.
REQ-022 Output slot SHALL hold contents stable while if_valid_o && !id_ready_i.
REQ-023 At most one request SHALL be outstanding; resp_valid_i in IDLE/REQ SHALL be ignored.

Reset
REQ-024 On rst_n low: state IDLE, pc = RESET_PC, req_valid_o=0, req_addr_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, if_excp_o=0.
REQ-025 Reset assertion mid-transaction SHALL abandon outstanding request with no DROP pending after release.

Configuration
REQ-026 With PC_ALIGN_CHECK_EN defined: pc[1:0]!=0 in REQ SHALL not issue a request, SHALL load slot with if_excp_o=1, if_instr_o=0, that pc, then stop in IDLE until a redirect.
REQ-027 Without PC_ALIGN_CHECK_EN: pc[1:0] forced to 0 on every redirect; if_excp_o tied 0.

Structure
REQ-028 Shared package SHALL hold RESET_PC default, FSM state encoding, and the 32-bit instruction/address width constants.
REQ-029 Output slot SHALL be a sub-module if_out_slot (single-entry valid/ready register with kill input); FSM and pc remain in if_pc_gen.

Verification
REQ-030 Reset release, req_ready_i=1, 1-cycle responses 0x11,0x22 -> req_addr_o 0x1C000000, 0x1C000004; if_pc_o/if_instr_o pairs match, in order.
REQ-031 branch_flag_i=1, target 0x1C000100 while in WAIT -> response discarded (DROP), next req_addr_o 0x1C000100.
REQ-032 flush_i=1 new_pc 0x1C000020 and branch_flag_i=1 same cycle -> next req_addr_o 0x1C000020, if_valid_o=0 next cycle.
REQ-033 id_ready_i=0 for 5 cycles with slot full -> slot stable, no new request issued.
REQ-034 PC_ALIGN_CHECK_EN, flush to 0x1C000022 -> no request, if_excp_o=1, if_pc_o=0x1C000022.
REQ-035 rst_n low during WAIT, stale resp_valid_i after release -> ignored, first fetch 0x1C000000.

Source files
------------

// File: rtl/if_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch PC generator: address and
// instruction widths, the default boot address and the fetch FSM encoding.
package if_pc_gen_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // Sequential successor of a fetch address; wraps naturally at 32 bits.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_out_slot.sv
// Single-entry valid/ready register holding the fetched instruction that is
// offered to the decode stage. A load always wins over a kill because the
// fetch unit only loads when the held entry is empty or leaving this cycle,
// so a kill arriving with a load can only refer to the outgoing entry.
module if_out_slot
  import if_pc_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic [ILEN-1:0] load_instr_i,
  input  logic            load_excp_i,
  input  logic            kill_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic            excp_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            excp_q;

  // Capture a new entry, otherwise drop the held one on kill or hand-off;
  // the payload is left untouched while the entry is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      excp_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc_i;
      instr_q <= load_instr_i;
      excp_q  <= load_excp_i;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign excp_o  = excp_q;

endmodule

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator. Keeps the fetch PC, issues at most one
// instruction-memory request at a time, handles flush/branch redirects and
// feeds fetched instructions into the output slot toward decode.
// Optional build macro PC_ALIGN_CHECK_EN: when defined, a misaligned PC
// raises a fetch exception and parks the unit until the next redirect;
// when undefined, redirect targets are word-aligned and if_excp_o stays 0.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [XLEN-1:0] new_pc_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            pc_instr_invalid_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            req_ready_i,
  input  logic            resp_valid_i,
  input  logic [ILEN-1:0] resp_instr_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [ILEN-1:0] if_instr_o,
  output logic            if_excp_o,
  input  logic            id_ready_i
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;

  logic            redirect;
  logic [XLEN-1:0] redirect_raw;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_misaligned;
  logic            slot_valid;
  logic            slot_free;
  logic            issue;
  logic            align_trap;
  logic            resp_take;
  logic            slot_load;
  logic [ILEN-1:0] slot_load_instr;
  logic            slot_load_excp;
  logic            slot_kill;

`ifdef PC_ALIGN_CHECK_EN
  logic            halt_q;
`endif

  // Redirect selection (flush outranks branch) and fetch-side decisions.
  always_comb begin
    redirect     = flush_i | branch_flag_i;
    redirect_raw = flush_i ? new_pc_i : branch_target_i;
`ifdef PC_ALIGN_CHECK_EN
    redirect_pc   = redirect_raw;
    pc_misaligned = (pc_q[1:0] != 2'b00);
`else
    redirect_pc   = redirect_raw & ~32'h0000_0003;
    pc_misaligned = 1'b0;
`endif
    slot_free  = !slot_valid || id_ready_i;
    issue      = (state_q == ST_REQ) && slot_free && !redirect && !pc_misaligned;
    align_trap = (state_q == ST_REQ) && slot_free && !redirect && pc_misaligned;
    resp_take  = (state_q == ST_WAIT) && resp_valid_i && !redirect;
    slot_load  = resp_take || align_trap;
    slot_load_instr = align_trap ? '0 : resp_instr_i;
    slot_load_excp  = align_trap;
    slot_kill  = flush_i || pc_instr_invalid_i ||
                 (branch_flag_i && !(slot_valid && id_ready_i));
  end

  assign req_valid_o = issue;
  assign req_addr_o  = issue ? pc_q : '0;

  // Fetch FSM and PC: one request in flight, redirects retarget the PC on
  // the same edge and any in-flight response is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
`ifdef PC_ALIGN_CHECK_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= ST_REQ;
`ifdef PC_ALIGN_CHECK_EN
            halt_q  <= 1'b0;
          end else if (!halt_q) begin
            state_q <= ST_REQ;
`else
          end else begin
            state_q <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else if (align_trap) begin
            state_q <= ST_IDLE;
`ifdef PC_ALIGN_CHECK_EN
            halt_q  <= 1'b1;
`endif
          end else if (issue && req_ready_i) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= resp_valid_i ? ST_REQ : ST_DROP;
          end else if (resp_valid_i) begin
            pc_q    <= next_seq_pc(pc_q);
            state_q <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          if (resp_valid_i) begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // In the default build the exception flag is only ever loaded with 0,
  // so if_excp_o is constant and trims away.
  if_out_slot u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (slot_load),
    .load_pc_i    (pc_q),
    .load_instr_i (slot_load_instr),
    .load_excp_i  (slot_load_excp),
    .kill_i       (slot_kill),
    .ready_i      (id_ready_i),
    .valid_o      (slot_valid),
    .pc_o         (if_pc_o),
    .instr_o      (if_instr_o),
    .excp_o       (if_excp_o)
  );

  assign if_valid_o = slot_valid;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed, table-driven bench for if_pc_gen. Each table row is one clock
// cycle: inputs driven after the falling edge, outputs compared shortly
// after, before the next rising edge.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        pc_instr_invalid_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_instr_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_excp_o;
  logic        id_ready_i;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        flush;
    logic [31:0] newPc;
    logic        br;
    logic [31:0] brTgt;
    logic        kill;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respInstr;
    logic        idReady;
    logic        eRv;
    logic [31:0] eRa;
    logic        eIv;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    logic        eExcp;
  } vec_t;

  vec_t tbl[$];
  vec_t seqTbl[$];

  always #5 clk = ~clk;

  if_pc_gen #(.RESET_PC(32'h1C00_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .new_pc_i           (new_pc_i),
    .branch_flag_i      (branch_flag_i),
    .branch_target_i    (branch_target_i),
    .pc_instr_invalid_i (pc_instr_invalid_i),
    .req_valid_o        (req_valid_o),
    .req_addr_o         (req_addr_o),
    .req_ready_i        (req_ready_i),
    .resp_valid_i       (resp_valid_i),
    .resp_instr_i       (resp_instr_i),
    .if_valid_o         (if_valid_o),
    .if_pc_o            (if_pc_o),
    .if_instr_o         (if_instr_o),
    .if_excp_o          (if_excp_o),
    .id_ready_i         (id_ready_i)
  );

  function automatic vec_t mkVec(
    input int f, input logic [31:0] np, input int b, input logic [31:0] bt,
    input int k, input int rr, input int rv, input logic [31:0] ri,
    input int idr, input int erv, input logic [31:0] era, input int eiv,
    input logic [31:0] epc, input logic [31:0] ein, input int eex);
    vec_t v;
    v.flush = (f != 0);     v.newPc = np;
    v.br = (b != 0);        v.brTgt = bt;
    v.kill = (k != 0);      v.reqReady = (rr != 0);
    v.respValid = (rv != 0); v.respInstr = ri;
    v.idReady = (idr != 0);
    v.eRv = (erv != 0);     v.eRa = era;
    v.eIv = (eiv != 0);     v.ePc = epc;
    v.eInstr = ein;         v.eExcp = (eex != 0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks the outputs, then waits for the
  // falling edge that follows the next rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    flush_i            = v.flush;
    new_pc_i           = v.newPc;
    branch_flag_i      = v.br;
    branch_target_i    = v.brTgt;
    pc_instr_invalid_i = v.kill;
    req_ready_i        = v.reqReady;
    resp_valid_i       = v.respValid;
    resp_instr_i       = v.respInstr;
    id_ready_i         = v.idReady;
    #1;
    checkOutput({tag, " req_valid"}, 32'(req_valid_o), 32'(v.eRv));
    if (v.eRv) checkOutput({tag, " req_addr"}, req_addr_o, v.eRa);
    checkOutput({tag, " if_valid"}, 32'(if_valid_o), 32'(v.eIv));
    if (v.eIv) begin
      checkOutput({tag, " if_pc"}, if_pc_o, v.ePc);
      checkOutput({tag, " if_instr"}, if_instr_o, v.eInstr);
      checkOutput({tag, " if_excp"}, 32'(if_excp_o), 32'(v.eExcp));
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_valid"}, 32'(req_valid_o), 32'h0);
    checkOutput({tag, " req_addr"}, req_addr_o, 32'h0);
    checkOutput({tag, " if_valid"}, 32'(if_valid_o), 32'h0);
    checkOutput({tag, " if_pc"}, if_pc_o, 32'h0);
    checkOutput({tag, " if_instr"}, if_instr_o, 32'h0);
    checkOutput({tag, " if_excp"}, 32'(if_excp_o), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0; new_pc_i = '0; branch_flag_i = 1'b0; branch_target_i = '0;
    pc_instr_invalid_i = 1'b0; req_ready_i = 1'b0; resp_valid_i = 1'b0;
    resp_instr_i = '0; id_ready_i = 1'b1;

    // Args: flush,newPc, br,brTgt, kill, reqReady, respValid,respInstr, idReady,
    //       expReqValid,expReqAddr, expIfValid,expIfPc,expIfInstr,expExcp
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));                 // IDLE
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000000,0,32'h0,32'h0,0));          // first req
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h11,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x11
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000004,1,32'h1C000000,32'h11,0));  // slot 0x11
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h22,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x22
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000004,32'h22,0));         // stall 1
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'hDEAD,0, 0,32'h0,1,32'h1C000004,32'h22,0));      // stall 2, stray resp
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000004,32'h22,0));         // stall 3
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000004,32'h22,0));         // stall 4
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000004,32'h22,0));         // stall 5
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000008,1,32'h1C000004,32'h22,0));  // release
    tbl.push_back(mkVec(0,32'h0,1,32'h1C000100,0,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));          // branch in WAIT
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h33,1, 0,32'h0,0,32'h0,32'h0,0));                // DROP eats 0x33
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,0,0,32'h0,1, 1,32'h1C000100,0,32'h0,32'h0,0));          // hold req
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,0,0,32'h0,1, 1,32'h1C000100,0,32'h0,32'h0,0));          // hold req
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000100,0,32'h0,32'h0,0));          // accept
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h44,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x44
    tbl.push_back(mkVec(1,32'h1C000020,1,32'h1C000300,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000100,32'h44,0)); // flush+branch
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,0,0,32'h0,1, 1,32'h1C000020,0,32'h0,32'h0,0));          // flush target
    tbl.push_back(mkVec(0,32'h0,1,32'h1C000040,0,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));          // branch in REQ
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000040,0,32'h0,32'h0,0));          // new req
    tbl.push_back(mkVec(1,32'h1C000080,0,32'h0,0,1,1,32'h55,1, 0,32'h0,0,32'h0,32'h0,0));         // flush + resp
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000080,0,32'h0,32'h0,0));          // req after
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h66,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x66
    tbl.push_back(mkVec(0,32'h0,0,32'h0,1,1,0,32'h0,0, 0,32'h0,1,32'h1C000080,32'h66,0));         // kill slot
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000084,0,32'h0,32'h0,0));          // killed
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h77,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x77
    tbl.push_back(mkVec(0,32'h0,1,32'h1C000200,0,1,0,32'h0,1, 0,32'h0,1,32'h1C000084,32'h77,0));  // branch + consume
    tbl.push_back(mkVec(1,32'hFFFFFFFC,0,32'h0,0,0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));          // flush to top
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'hFFFFFFFC,0,32'h0,32'h0,0));          // top req
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h88,1, 0,32'h0,0,32'h0,32'h0,0));                // resp 0x88
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,0,0,32'h0,1, 1,32'h00000000,1,32'hFFFFFFFC,32'h88,0));  // wrapped pc
    tbl.push_back(mkVec(1,32'h1C000022,0,32'h0,0,0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));          // misaligned flush
`ifdef PC_ALIGN_CHECK_EN
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,0,32'h0,32'h0,0));                 // trap, no req
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000022,32'h0,1));          // excp in slot
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000022,32'h0,1));          // parked
`else
    tbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000020,0,32'h0,32'h0,0));          // aligned target
`endif

    // Reset mid-transaction, then stray responses after release.
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));               // IDLE
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000000,0,32'h0,32'h0,0));        // req
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0));               // WAIT
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'hBAD,1, 0,32'h0,0,32'h0,32'h0,0));             // stale in IDLE
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,0,1,32'hBAD,1, 1,32'h1C000000,0,32'h0,32'h0,0));      // stale in REQ
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,1, 1,32'h1C000000,0,32'h0,32'h0,0));        // accept
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,1,32'h99,1, 0,32'h0,0,32'h0,32'h0,0));              // resp 0x99
    seqTbl.push_back(mkVec(0,32'h0,0,32'h0,0,1,0,32'h0,0, 0,32'h0,1,32'h1C000000,32'h99,0));       // slot 0x99

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seqTbl[i], $sformatf("rst_seq%0d", i));
    end
    rst_n = 1'b0;
    resp_valid_i = 1'b0;
    #1;
    checkResetOutputs("mid_wait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i < seqTbl.size(); i++) begin
      applyStimulus(seqTbl[i], $sformatf("rst_seq%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
